// File: rtl/alu_exec_if.sv
// Handshake and data bundle between the control decoder and the execute ALU.
interface alu_exec_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_inst;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             branch_taken;
    logic             illegal;

    // Producer of operations / consumer of results.
    modport master (
        output in_valid, alu_inst, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, carry, zero, branch_taken, illegal
    );

    // The ALU itself.
    modport slave (
        input  in_valid, alu_inst, op_a, op_b, out_ready,
        output in_ready, out_valid, result, carry, zero, branch_taken, illegal
    );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle arithmetic/compare, bit-serial shifts,
// registered result/flags held until the downstream handshake.
module alu_exec #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    alu_exec_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SFL = 4'b0010;
    localparam logic [3:0] OP_SFR = 4'b0011;
    localparam logic [3:0] OP_INC = 4'b0100;
    localparam logic [3:0] OP_DEC = 4'b0101;
    localparam logic [3:0] OP_BNE = 4'b0110;
    localparam logic [3:0] OP_BEQ = 4'b0111;
    localparam logic [3:0] OP_BLT = 4'b1000;

    logic [1:0]       state;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             zero_q;
    logic             branch_q;
    logic             illegal_q;
    logic             shift_left;
    logic [SW-1:0]    count;

    logic [SW-1:0]    amount;
    logic             is_shift;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   dec;
    logic [WIDTH-1:0] res_n;
    logic             carry_n;
    logic             branch_n;
    logic             illegal_n;
    logic [WIDTH-1:0] shifted;
    logic             shift_out;

    assign amount   = bus.op_b[SW-1:0];
    assign is_shift = (bus.alu_inst == OP_SFL) || (bus.alu_inst == OP_SFR);

    // Single-cycle result for everything that does not need the shifter.
    always_comb begin
        sum       = {1'b0, bus.op_a} + {1'b0, bus.op_b};
        diff      = {1'b0, bus.op_a} - {1'b0, bus.op_b};
        inc       = {1'b0, bus.op_a} + (WIDTH + 1)'(1);
        dec       = {1'b0, bus.op_a} - (WIDTH + 1)'(1);
        res_n     = '0;
        carry_n   = 1'b0;
        branch_n  = 1'b0;
        illegal_n = 1'b0;
        case (bus.alu_inst)
            OP_ADD: begin
                res_n   = sum[WIDTH-1:0];
                carry_n = sum[WIDTH];
            end
            OP_SUB: begin
                res_n   = diff[WIDTH-1:0];
                carry_n = diff[WIDTH];
            end
            OP_SFL, OP_SFR: begin
                // only reached here for a zero shift amount
                res_n = bus.op_a;
            end
            OP_INC: begin
                res_n   = inc[WIDTH-1:0];
                carry_n = inc[WIDTH];
            end
            OP_DEC: begin
                res_n   = dec[WIDTH-1:0];
                carry_n = dec[WIDTH];
            end
            OP_BNE: begin
                res_n    = diff[WIDTH-1:0];
                carry_n  = diff[WIDTH];
                branch_n = (bus.op_a != bus.op_b);
            end
            OP_BEQ: begin
                res_n    = diff[WIDTH-1:0];
                carry_n  = diff[WIDTH];
                branch_n = (bus.op_a == bus.op_b);
            end
            OP_BLT: begin
                res_n    = diff[WIDTH-1:0];
                carry_n  = diff[WIDTH];
                branch_n = diff[WIDTH];
            end
            default: begin
                illegal_n = 1'b1;
            end
        endcase
    end

    // One-bit shift step of the work register (the result register doubles as it).
    always_comb begin
        shifted   = shift_left ? (result_q << 1) : (result_q >> 1);
        shift_out = shift_left ? result_q[WIDTH-1] : result_q[0];
    end

    // Control FSM plus result/flag registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            branch_q   <= 1'b0;
            illegal_q  <= 1'b0;
            shift_left <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (is_shift && (amount != '0)) begin
                            state      <= SHIFT;
                            count      <= amount;
                            result_q   <= bus.op_a;
                            carry_q    <= 1'b0;
                            zero_q     <= 1'b0;
                            branch_q   <= 1'b0;
                            illegal_q  <= 1'b0;
                            shift_left <= (bus.alu_inst == OP_SFL);
                        end else begin
                            state     <= DONE;
                            result_q  <= res_n;
                            carry_q   <= carry_n;
                            zero_q    <= (res_n == '0);
                            branch_q  <= branch_n;
                            illegal_q <= illegal_n;
                        end
                    end
                end
                SHIFT: begin
                    result_q <= shifted;
                    carry_q  <= shift_out;
                    count    <= count - 1'b1;
                    if (count == SW'(1)) begin
                        state  <= DONE;
                        zero_q <= (shifted == '0);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready     = (state == IDLE);
    assign bus.out_valid    = (state == DONE);
    assign bus.result       = result_q;
    assign bus.carry        = carry_q;
    assign bus.zero         = zero_q;
    assign bus.branch_taken = branch_q;
    assign bus.illegal      = illegal_q;
endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU for the 8-bit core, sitting on the consuming end of the control decoder's 4-bit `alu_inst` bus. Accepts one decoded ALU operation plus two operands over a valid/ready handshake, computes the result (single-cycle for arithmetic and compare ops, one bit per cycle for shifts), and presents a registered result, flags, and branch decision downstream until they are taken.

## Interface
- `WIDTH`, 8: datapath width in bits; power of two, at least 4.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation and operands present.
- `in_ready` out 1: block can accept; equals (state == IDLE).
- `alu_inst` in 4: ALU opcode, encoded as follows.
  - ADD=0000, SUB=0001, SFL=0010, SFR=0011, INC=0100, DEC=0101, BNE=0110, BEQ=0111, BLT=1000.
  - 1001–1111 are illegal.
- `op_a` in WIDTH: first operand, or the value being shifted.
- `op_b` in WIDTH: second operand; for shifts the amount is `op_b[log2(WIDTH)-1:0]`.
- `out_valid` out 1: result registers hold a completed operation.
- `out_ready` in 1: downstream takes the result.
- `result` out WIDTH: registered result.
- `carry` out 1: carry/borrow/shifted-out bit.
- `zero` out 1: `result == 0`.
- `branch_taken` out 1: branch condition true. Only BNE/BEQ/BLT can set it.
- `illegal` out 1: the operation was an illegal opcode.

## Operation
- States: IDLE, SHIFT, DONE.
- Accept happens when `in_valid && in_ready`. Operands and opcode are captured at that edge. Inputs are ignored at all other times.
- From IDLE, an accepted operation goes to:
  - SHIFT, for SFL/SFR with amount n ≥ 1. The counter loads n, the work register loads `op_a`, and `carry` clears.
  - DONE, for all other opcodes and for shifts with n = 0. Outputs are computed and registered at the accept edge.
- SHIFT:
  - Each cycle shifts the work register one bit: SFL left, SFR logical right, zero fill.
  - `carry` takes the bit shifted out; the counter decrements.
  - When the counter goes 1→0, the next state is DONE.
- DONE: outputs are held stable while `out_valid` = 1. `out_valid && out_ready` returns the block to IDLE. No accept occurs in DONE.
- Arithmetic, all modulo 2^WIDTH, unsigned:
  - ADD: result = a+b; carry = carry-out.
  - SUB: result = a−b; carry = (a < b) borrow.
  - INC: result = a+1; carry = (a == all-ones).
  - DEC: result = a−1; carry = (a == 0).
  - BNE/BEQ/BLT: result = a−b; carry = (a < b). branch_taken is a≠b, a==b, and a<b (unsigned) respectively.
  - Shift with n = 0: result = a; carry = 0.
- `branch_taken` = 0 for every non-branch opcode.
- Illegal opcode: result = 0, carry = 0, branch_taken = 0, `illegal` = 1, `zero` = 1. Goes straight to DONE.
- X or Z on `alu_inst` while `in_valid` = 1 is a protocol violation. The bench flags it; the RTL is not required to handle it.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert handled upstream):
  - state = IDLE, so `in_ready` = 1.
  - `out_valid`, `result`, `carry`, `zero`, `branch_taken`, `illegal` are all 0.
  - Shift counter is 0.
- Latency, counted from the accept edge at cycle 0:
  - Non-shift ops and n = 0 shifts: `out_valid` = 1 in cycle 1.
  - Shifts with n ≥ 1: `out_valid` = 1 in cycle n+1.
- `in_ready` is 0 from cycle 1 until the cycle after the output handshake. Minimum issue interval is 2 cycles with `out_ready` held high.
- `out_ready` is a don't-care while `out_valid` = 0.
- Outputs must not change between `out_valid` rising and the handshake edge.
- `reset_n` asserted in SHIFT or DONE aborts the operation immediately. No `out_valid` is produced for it, and the block is in IDLE on deassert.
- Maximum shift amount WIDTH−1 (7 at default) gives a worst-case latency of WIDTH cycles.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-SHIFT (SFL a=0x81, n=5, after 2 shift cycles) → all outputs 0 immediately, `in_ready` = 1; after release, no `out_valid` appears.
- **ADD with backpressure:** ADD a=0xF0, b=0x20 with `out_ready` low for 3 cycles → `out_valid` at cycle 1, held; result=0x10, carry=1, zero=0. Values are stable until the handshake; `in_ready` = 1 the cycle after.
- **SUB/DEC borrow:** SUB a=0x05, b=0x05 → result=0x00, zero=1, carry=0. DEC a=0x00 → result=0xFF, carry=1.
- **Shifts:**
  - SFR a=0xB3, n=3 → `out_valid` at cycle 4, result=0x16, carry=0.
  - SFL a=0xB3, n=1 → cycle 2, result=0x66, carry=1.
  - SFL n=0 → cycle 1, result=0xB3, carry=0.
- **Branches:**
  - BLT a=0x02, b=0x80 → branch_taken=1, carry=1.
  - BEQ a=0x3C, b=0x3C → branch_taken=1, zero=1.
  - BNE on the same operands → branch_taken=0.
  - ADD directly after → branch_taken=0.
- **Illegal/handshake:** `alu_inst`=1001 → illegal=1, result=0, zero=1, latency 1. `in_valid` asserted during DONE is not accepted: the opcode changing in DONE has no effect, and the op is taken only after returning to IDLE.
